mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares one port of the 64K×16 dual-port data memory among NUM_REQ requesters (CPU load/store unit, VGA line fetcher, I/O DMA) using registered round-robin arbitration with optional burst locking. It sits between the requesters and the memory's port B, drives that port's address, write data and write enable, and routes the read data back. Throughput is one access per cycle; read data returns with fixed latency.

## Interface
Parameters:
- NUM_REQ, 3, number of requesters (2..8); index 0 = CPU
- ADDR_WIDTH, 16, memory address width
- DATA_WIDTH, 16, memory word width
- MAX_BURST, 8, max consecutive grants to a locked owner (1..255)

Ports:
- clock  in  1  system clock; all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- req  in  NUM_REQ  request per requester; held with its fields until gnt
- we  in  NUM_REQ  1 = write, 0 = read
- lock  in  NUM_REQ  keep the grant for back-to-back accesses
- addr  in  NUM_REQ*ADDR_WIDTH  packed addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- wdata  in  NUM_REQ*DATA_WIDTH  packed write data
- gnt  out  NUM_REQ  one-hot, one-cycle accept pulse
- rvalid  out  NUM_REQ  one-hot, one-cycle read-data-valid pulse
- rdata  out  DATA_WIDTH  read data, shared by all requesters
- mem_address  out  ADDR_WIDTH  to memory port address
- mem_write_data  out  DATA_WIDTH  to memory port write data
- mem_write_enable  out  1  to memory port write enable
- mem_read_data  in  DATA_WIDTH  from memory port read data (memory registers it on falling edge)

## Operation
- FSM states: OPEN (round-robin among all) and BURST (last winner holds priority).
- OPEN: at each rising edge with any req, pick the first set req starting at rr_ptr, wrapping modulo NUM_REQ. Set rr_ptr = winner+1 (mod NUM_REQ). If the winner has lock, go to BURST with burst_cnt = 1.
- BURST: if the owner has req and lock, it wins regardless of other requests and burst_cnt increments. If burst_cnt == MAX_BURST, or the owner drops lock or req, the owner does not win this edge: arbitrate as OPEN with rr_ptr = owner+1, clear burst_cnt, and return to OPEN.
- Win: register mem_address/mem_write_data/mem_write_enable from the winner and pulse gnt[winner]. For a read, mark it in flight (tag = winner).
- No req: mem_write_enable = 0; mem_address and mem_write_data hold.
- Read return: one edge after issue, capture mem_read_data into rdata and pulse rvalid[tag]. rdata holds until the next read return.
- Writes: completion is implied by gnt; rvalid is never pulsed for a write.
- A requester that keeps req high during its gnt cycle is making a new request for the next edge.

## Timing
- Edge E0 (req sampled): gnt[i], mem_* valid for cycle E0→E1; the memory samples them on the falling edge inside that cycle.
- Edge E1: rdata valid and rvalid[i] = 1 for cycle E1→E2. Read latency = 2 edges from request sample. Issue rate = 1 per cycle; a new issue at E1 overlaps the return.
- Reset values: gnt = 0, rvalid = 0, rdata = 0, mem_address = 0, mem_write_data = 0, mem_write_enable = 0, rr_ptr = 0, burst_cnt = 0, state OPEN, no read in flight.
- Reset mid-operation: an in-flight read is dropped (no rvalid). A write issued in the cycle reset asserts is not guaranteed to land.
- Simultaneous requests: exactly one gnt per edge, never more.
- rr_ptr wraps from NUM_REQ-1 to 0.
- MAX_BURST = 1: lock has no effect beyond one grant.

## Structure
- Package mem_arb_pkg: state enum (OPEN, BURST) and burst counter width function clog2(MAX_BURST+1).
- Sub-module rr_pick: combinational priority picker with inputs req and start pointer, outputs one-hot winner plus index. It is reused by the upcoming I/O bus arbiter.

## Test plan
- Single read: req[1], addr 0x0040, memory holds 0xBEEF -> gnt[1] cycle after E0, rvalid[1] with rdata 0xBEEF one cycle later.
- All three requesters read continuously with no lock -> grants 0,1,2,0,1,2…; rvalid tags match the same order, one cycle behind.
- req[2] with lock for 12 reads, MAX_BURST = 8, req[0] also pending -> 8 consecutive gnt[2], then gnt[0], then gnt[2] resumes.
- Back-to-back: write 0x1234 to 0x0100, then read 0x0100 the next cycle -> rdata 0x1234.
- reset_n low during a read's issue cycle -> all outputs 0 immediately, no rvalid after release, next grant goes to requester 0.
- No requests for 5 cycles -> mem_write_enable = 0 and gnt = 0 throughout.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and sizing helpers for the memory-port arbiter and related arbiters.
package mem_arb_pkg;

  typedef enum logic {
    OPEN,
    BURST
  } arb_state_e;

  function automatic int clog2(input int value);
    int width;
    width = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) width = i + 1;
    end
    return width;
  endfunction

  // Counter must be able to hold MAX_BURST itself, hence the +1.
  function automatic int burst_cnt_width(input int maxBurst);
    return clog2(maxBurst + 1);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker: first set request at or after start_i, wrapping.
module rr_pick #(
  parameter int N    = 3,
  parameter int IDXW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req_i,
  input  logic [IDXW-1:0] start_i,
  output logic [N-1:0]    onehot_o,
  output logic [IDXW-1:0] idx_o,
  output logic            valid_o
);

  always_comb begin
    logic [IDXW-1:0] candIdx;
    onehot_o = '0;
    idx_o    = '0;
    valid_o  = 1'b0;
    candIdx  = '0;
    for (int k = 0; k < N; k++) begin
      candIdx = IDXW'((int'(start_i) + k) % N);
      if (!valid_o && req_i[candIdx]) begin
        valid_o           = 1'b1;
        idx_o             = candIdx;
        onehot_o[candIdx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter with burst locking that shares one data-memory port among
// several requesters and routes fixed-latency read data back to the issuer.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ    = 3,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int MAX_BURST  = 8
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            we,
  input  logic [NUM_REQ-1:0]            lock,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] wdata,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            rvalid,
  output logic [DATA_WIDTH-1:0]         rdata,
  output logic [ADDR_WIDTH-1:0]         mem_address,
  output logic [DATA_WIDTH-1:0]         mem_write_data,
  output logic                          mem_write_enable,
  input  logic [DATA_WIDTH-1:0]         mem_read_data
);

  localparam int IDXW = clog2(NUM_REQ);
  localparam int CNTW = burst_cnt_width(MAX_BURST);

  arb_state_e      state_q, state_d;
  logic [IDXW-1:0] owner_q, owner_d;
  logic [IDXW-1:0] rrPtr_q, rrPtr_d;
  logic [CNTW-1:0] burstCnt_q, burstCnt_d;

  logic [NUM_REQ-1:0]    gnt_q, gnt_d;
  logic [NUM_REQ-1:0]    rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [ADDR_WIDTH-1:0] memAddr_q, memAddr_d;
  logic [DATA_WIDTH-1:0] memWdata_q, memWdata_d;
  logic                  memWe_q, memWe_d;
  logic                  inflight_q, inflight_d;
  logic [IDXW-1:0]       tag_q, tag_d;

  logic [NUM_REQ-1:0] pickOneHot;
  logic [IDXW-1:0]    pickIdx;
  logic               pickValid;
  logic               ownerHolds;
  logic               winValid;
  logic [IDXW-1:0]    winIdx;
  logic [NUM_REQ-1:0] winOneHot;

  rr_pick #(
    .N    (NUM_REQ),
    .IDXW (IDXW)
  ) u_pick (
    .req_i    (req),
    .start_i  (rrPtr_q),
    .onehot_o (pickOneHot),
    .idx_o    (pickIdx),
    .valid_o  (pickValid)
  );

  assign ownerHolds = (state_q == BURST) && req[owner_q] && lock[owner_q] &&
                      (burstCnt_q != CNTW'(MAX_BURST));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= OPEN;
      owner_q    <= '0;
      rrPtr_q    <= '0;
      burstCnt_q <= '0;
      gnt_q      <= '0;
      rvalid_q   <= '0;
      rdata_q    <= '0;
      memAddr_q  <= '0;
      memWdata_q <= '0;
      memWe_q    <= 1'b0;
      inflight_q <= 1'b0;
      tag_q      <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rrPtr_q    <= rrPtr_d;
      burstCnt_q <= burstCnt_d;
      gnt_q      <= gnt_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      memAddr_q  <= memAddr_d;
      memWdata_q <= memWdata_d;
      memWe_q    <= memWe_d;
      inflight_q <= inflight_d;
      tag_q      <= tag_d;
    end
  end

  // rrPtr stays at owner+1 throughout a burst, so leaving a burst just resumes the rotation.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rrPtr_d    = rrPtr_q;
    burstCnt_d = burstCnt_q;
    winValid   = 1'b0;
    winIdx     = '0;
    winOneHot  = '0;
    if (ownerHolds) begin
      winValid   = 1'b1;
      winIdx     = owner_q;
      winOneHot  = NUM_REQ'(1) << owner_q;
      burstCnt_d = burstCnt_q + CNTW'(1);
    end else begin
      state_d    = OPEN;
      burstCnt_d = '0;
      if (pickValid) begin
        winValid  = 1'b1;
        winIdx    = pickIdx;
        winOneHot = pickOneHot;
        rrPtr_d   = (pickIdx == IDXW'(NUM_REQ - 1)) ? '0 : pickIdx + IDXW'(1);
        if (lock[pickIdx]) begin
          state_d    = BURST;
          owner_d    = pickIdx;
          burstCnt_d = CNTW'(1);
        end
      end
    end
  end

  always_comb begin
    gnt_d      = winOneHot;
    memAddr_d  = memAddr_q;
    memWdata_d = memWdata_q;
    memWe_d    = 1'b0;
    inflight_d = 1'b0;
    tag_d      = tag_q;
    if (winValid) begin
      memAddr_d  = addr[int'(winIdx) * ADDR_WIDTH +: ADDR_WIDTH];
      memWdata_d = wdata[int'(winIdx) * DATA_WIDTH +: DATA_WIDTH];
      memWe_d    = we[winIdx];
      inflight_d = !we[winIdx];
      tag_d      = winIdx;
    end
    // Memory output registered on the falling edge is stable by the next rising edge.
    rvalid_d = inflight_q ? (NUM_REQ'(1) << tag_q) : '0;
    rdata_d  = inflight_q ? mem_read_data : rdata_q;
  end

  assign gnt              = gnt_q;
  assign rvalid           = rvalid_q;
  assign rdata            = rdata_q;
  assign mem_address      = memAddr_q;
  assign mem_write_data   = memWdata_q;
  assign mem_write_enable = memWe_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a behavioural memory on port B, expected
// grants and read returns queued as stimulus is driven and compared as they appear.
module tb_mem_port_arbiter;

  localparam int NREQ = 3;
  localparam int AW   = 16;
  localparam int DW   = 16;

  logic                 clock;
  logic                 reset_n;
  logic [NREQ-1:0]      req, we, lock;
  logic [NREQ*AW-1:0]   addr;
  logic [NREQ*DW-1:0]   wdata;
  logic [NREQ-1:0]      gnt, rvalid;
  logic [DW-1:0]        rdata;
  logic [AW-1:0]        mem_address;
  logic [DW-1:0]        mem_write_data;
  logic                 mem_write_enable;
  logic [DW-1:0]        mem_read_data;

  logic [DW-1:0] benchMem [0:65535];
  logic [DW-1:0] refMem [int];

  typedef struct {
    int            tag;
    logic [DW-1:0] data;
    int            due;
  } readExp_t;

  readExp_t readQ[$];
  int       gntQ[$];
  int       remaining [NREQ];
  int       passCount;
  int       checkCount;

  mem_port_arbiter #(
    .NUM_REQ    (NREQ),
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .MAX_BURST  (8)
  ) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .req              (req),
    .we               (we),
    .lock             (lock),
    .addr             (addr),
    .wdata            (wdata),
    .gnt              (gnt),
    .rvalid           (rvalid),
    .rdata            (rdata),
    .mem_address      (mem_address),
    .mem_write_data   (mem_write_data),
    .mem_write_enable (mem_write_enable),
    .mem_read_data    (mem_read_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Port B of the data memory: samples on the falling edge, registered read data.
  always @(negedge clock) begin
    if (mem_write_enable) benchMem[mem_address] <= mem_write_data;
    mem_read_data <= benchMem[mem_address];
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic driveReq(input int i, input logic r, input logic w, input logic l,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[i]            = r;
    we[i]             = w;
    lock[i]           = l;
    addr[i*AW +: AW]  = a;
    wdata[i*DW +: DW] = d;
  endtask

  // Requesters drop req (and lock) once their planned number of accesses is granted.
  task automatic releaseGranted();
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i] && remaining[i] > 0) begin
        remaining[i]--;
        if (remaining[i] == 0) begin
          req[i]  = 1'b0;
          lock[i] = 1'b0;
        end
      end
    end
  endtask

  task automatic applyReset();
    reset_n = 1'b0;
    req = '0; we = '0; lock = '0; addr = '0; wdata = '0;
    gntQ.delete();
    readQ.delete();
    for (int i = 0; i < NREQ; i++) remaining[i] = 0;
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    req = '0; we = '0; lock = '0; addr = '0; wdata = '0;
    repeat (2) @(posedge clock);
    #1;
    checkCount++; if (gnt !== 3'b000) $display("[TB] FAIL reset_gnt: got %b want 000", gnt); else passCount++;
    checkCount++; if (rvalid !== 3'b000) $display("[TB] FAIL reset_rvalid: got %b want 000", rvalid); else passCount++;
    checkCount++; if (rdata !== 16'h0000) $display("[TB] FAIL reset_rdata: got %h want 0000", rdata); else passCount++;
    checkCount++; if (mem_address !== 16'h0000) $display("[TB] FAIL reset_addr: got %h want 0000", mem_address); else passCount++;
    checkCount++; if (mem_write_data !== 16'h0000) $display("[TB] FAIL reset_wdata: got %h want 0000", mem_write_data); else passCount++;
    checkCount++; if (mem_write_enable !== 1'b0) $display("[TB] FAIL reset_we: got %b want 0", mem_write_enable); else passCount++;
    reset_n = 1'b1;
  endtask

  task automatic test_single_read();
    readExp_t r;
    applyReset();
    driveReq(0, 1'b1, 1'b1, 1'b0, 16'h0040, 16'hBEEF);
    refMem[32'h0040] = 16'hBEEF;
    tick();
    checkCount++; if (gnt !== 3'b001) $display("[TB] FAIL sr_wr_gnt: got %b want 001", gnt); else passCount++;
    checkCount++; if (mem_write_enable !== 1'b1) $display("[TB] FAIL sr_wr_we: got %b want 1", mem_write_enable); else passCount++;
    checkCount++; if (mem_address !== 16'h0040) $display("[TB] FAIL sr_wr_addr: got %h want 0040", mem_address); else passCount++;
    checkCount++; if (mem_write_data !== 16'hBEEF) $display("[TB] FAIL sr_wr_data: got %h want BEEF", mem_write_data); else passCount++;
    driveReq(0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    driveReq(1, 1'b1, 1'b0, 1'b0, 16'h0040, 16'h0000);
    r.tag = 1; r.data = refMem[32'h0040]; r.due = 1;
    readQ.push_back(r);
    tick();
    checkCount++; if (gnt !== 3'b010) $display("[TB] FAIL sr_rd_gnt: got %b want 010", gnt); else passCount++;
    checkCount++; if (mem_write_enable !== 1'b0) $display("[TB] FAIL sr_rd_we: got %b want 0", mem_write_enable); else passCount++;
    checkCount++; if (rvalid !== 3'b000) $display("[TB] FAIL sr_early_rvalid: got %b want 000", rvalid); else passCount++;
    driveReq(1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    tick();
    r = readQ.pop_front();
    checkCount++; if (rvalid !== (3'b001 << r.tag)) $display("[TB] FAIL sr_rvalid: got %b want %b", rvalid, 3'b001 << r.tag); else passCount++;
    checkCount++; if (rdata !== r.data) $display("[TB] FAIL sr_rdata: got %h want %h", rdata, r.data); else passCount++;
    checkCount++; if (gnt !== 3'b000) $display("[TB] FAIL sr_idle_gnt: got %b want 000", gnt); else passCount++;
    tick();
    checkCount++; if (rvalid !== 3'b000) $display("[TB] FAIL sr_rvalid_pulse: got %b want 000", rvalid); else passCount++;
    checkCount++; if (rdata !== 16'hBEEF) $display("[TB] FAIL sr_rdata_hold: got %h want BEEF", rdata); else passCount++;
  endtask

  task automatic test_round_robin();
    logic [NREQ-1:0] expG;
    readExp_t        r;
    applyReset();
    for (int i = 0; i < NREQ; i++) begin
      driveReq(i, 1'b1, 1'b1, 1'b0, 16'h0200 + 16'(i), 16'hA000 + 16'(i));
      refMem[32'h0200 + i] = 16'hA000 + 16'(i);
      gntQ.push_back(i);
      remaining[i] = 1;
    end
    for (int t = 0; t < NREQ; t++) begin
      tick();
      expG = NREQ'(1) << gntQ.pop_front();
      checkCount++; if (gnt !== expG) $display("[TB] FAIL rr_wr_gnt t%0d: got %b want %b", t, gnt, expG); else passCount++;
      checkCount++; if (mem_write_enable !== 1'b1) $display("[TB] FAIL rr_wr_we t%0d: got %b want 1", t, mem_write_enable); else passCount++;
      releaseGranted();
    end
    for (int i = 0; i < NREQ; i++) begin
      driveReq(i, 1'b1, 1'b0, 1'b0, 16'h0200 + 16'(i), 16'h0000);
      remaining[i] = 3;
    end
    for (int k = 0; k < 9; k++) begin
      gntQ.push_back(k % 3);
      r.tag = k % 3; r.data = refMem[32'h0200 + (k % 3)]; r.due = k + 1;
      readQ.push_back(r);
    end
    for (int t = 0; t < 10; t++) begin
      tick();
      expG = '0;
      if (gntQ.size() > 0) expG = NREQ'(1) << gntQ.pop_front();
      checkCount++; if (gnt !== expG) $display("[TB] FAIL rr_rd_gnt t%0d: got %b want %b", t, gnt, expG); else passCount++;
      if (readQ.size() > 0 && readQ[0].due == t) begin
        r = readQ.pop_front();
        checkCount++; if (rvalid !== (NREQ'(1) << r.tag)) $display("[TB] FAIL rr_rvalid t%0d: got %b want %b", t, rvalid, NREQ'(1) << r.tag); else passCount++;
        checkCount++; if (rdata !== r.data) $display("[TB] FAIL rr_rdata t%0d: got %h want %h", t, rdata, r.data); else passCount++;
      end else begin
        checkCount++; if (rvalid !== 3'b000) $display("[TB] FAIL rr_rvalid_idle t%0d: got %b want 000", t, rvalid); else passCount++;
      end
      releaseGranted();
    end
  endtask

  task automatic test_burst_lock();
    logic [NREQ-1:0] expG;
    readExp_t        r;
    int              seq[$];
    applyReset();
    driveReq(2, 1'b1, 1'b0, 1'b1, 16'h0202, 16'h0000);
    remaining[2] = 12;
    remaining[0] = 1;
    // Eight locked grants to requester 2, then the waiting requester 0, then 2 resumes.
    for (int k = 0; k < 8; k++) seq.push_back(2);
    seq.push_back(0);
    for (int k = 0; k < 4; k++) seq.push_back(2);
    for (int k = 0; k < seq.size(); k++) begin
      gntQ.push_back(seq[k]);
      r.tag = seq[k]; r.data = refMem[32'h0200 + seq[k]]; r.due = k + 1;
      readQ.push_back(r);
    end
    for (int t = 0; t < 14; t++) begin
      tick();
      expG = '0;
      if (gntQ.size() > 0) expG = NREQ'(1) << gntQ.pop_front();
      checkCount++; if (gnt !== expG) $display("[TB] FAIL burst_gnt t%0d: got %b want %b", t, gnt, expG); else passCount++;
      if (readQ.size() > 0 && readQ[0].due == t) begin
        r = readQ.pop_front();
        checkCount++; if (rvalid !== (NREQ'(1) << r.tag)) $display("[TB] FAIL burst_rvalid t%0d: got %b want %b", t, rvalid, NREQ'(1) << r.tag); else passCount++;
        checkCount++; if (rdata !== r.data) $display("[TB] FAIL burst_rdata t%0d: got %h want %h", t, rdata, r.data); else passCount++;
      end
      releaseGranted();
      if (t == 0) driveReq(0, 1'b1, 1'b0, 1'b0, 16'h0200, 16'h0000);
    end
  endtask

  task automatic test_back_to_back();
    readExp_t r;
    applyReset();
    driveReq(1, 1'b1, 1'b1, 1'b0, 16'h0100, 16'h1234);
    refMem[32'h0100] = 16'h1234;
    tick();
    checkCount++; if (gnt !== 3'b010) $display("[TB] FAIL b2b_wr_gnt: got %b want 010", gnt); else passCount++;
    checkCount++; if (mem_write_enable !== 1'b1) $display("[TB] FAIL b2b_wr_we: got %b want 1", mem_write_enable); else passCount++;
    driveReq(1, 1'b1, 1'b0, 1'b0, 16'h0100, 16'h0000);
    r.tag = 1; r.data = refMem[32'h0100]; r.due = 0;
    readQ.push_back(r);
    tick();
    checkCount++; if (gnt !== 3'b010) $display("[TB] FAIL b2b_rd_gnt: got %b want 010", gnt); else passCount++;
    checkCount++; if (mem_write_enable !== 1'b0) $display("[TB] FAIL b2b_rd_we: got %b want 0", mem_write_enable); else passCount++;
    checkCount++; if (mem_address !== 16'h0100) $display("[TB] FAIL b2b_rd_addr: got %h want 0100", mem_address); else passCount++;
    driveReq(1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    tick();
    r = readQ.pop_front();
    checkCount++; if (rvalid !== (3'b001 << r.tag)) $display("[TB] FAIL b2b_rvalid: got %b want %b", rvalid, 3'b001 << r.tag); else passCount++;
    checkCount++; if (rdata !== r.data) $display("[TB] FAIL b2b_rdata: got %h want %h", rdata, r.data); else passCount++;
  endtask

  task automatic test_reset_mid();
    readExp_t r;
    applyReset();
    driveReq(1, 1'b1, 1'b0, 1'b0, 16'h0100, 16'h0000);
    tick();
    checkCount++; if (gnt !== 3'b010) $display("[TB] FAIL rm_gnt: got %b want 010", gnt); else passCount++;
    #2 reset_n = 1'b0;
    driveReq(1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    #1;
    checkCount++; if (gnt !== 3'b000) $display("[TB] FAIL rm_async_gnt: got %b want 000", gnt); else passCount++;
    checkCount++; if (mem_address !== 16'h0000) $display("[TB] FAIL rm_async_addr: got %h want 0000", mem_address); else passCount++;
    checkCount++; if (mem_write_data !== 16'h0000) $display("[TB] FAIL rm_async_wdata: got %h want 0000", mem_write_data); else passCount++;
    checkCount++; if (mem_write_enable !== 1'b0) $display("[TB] FAIL rm_async_we: got %b want 0", mem_write_enable); else passCount++;
    checkCount++; if (rdata !== 16'h0000) $display("[TB] FAIL rm_async_rdata: got %h want 0000", rdata); else passCount++;
    #2 reset_n = 1'b1;
    for (int t = 0; t < 3; t++) begin
      tick();
      checkCount++; if (rvalid !== 3'b000) $display("[TB] FAIL rm_dropped_rvalid t%0d: got %b want 000", t, rvalid); else passCount++;
    end
    driveReq(0, 1'b1, 1'b0, 1'b0, 16'h0200, 16'h0000);
    driveReq(2, 1'b1, 1'b0, 1'b0, 16'h0202, 16'h0000);
    r.tag = 0; r.data = refMem[32'h0200]; r.due = 0;
    readQ.push_back(r);
    tick();
    checkCount++; if (gnt !== 3'b001) $display("[TB] FAIL rm_first_gnt: got %b want 001", gnt); else passCount++;
    driveReq(0, 1'b0, 1'b0, 1'b0, 16'h0200, 16'h0000);
    driveReq(2, 1'b0, 1'b0, 1'b0, 16'h0202, 16'h0000);
    tick();
    r = readQ.pop_front();
    checkCount++; if (rvalid !== (3'b001 << r.tag)) $display("[TB] FAIL rm_rvalid: got %b want %b", rvalid, 3'b001 << r.tag); else passCount++;
    checkCount++; if (rdata !== r.data) $display("[TB] FAIL rm_rdata: got %h want %h", rdata, r.data); else passCount++;
  endtask

  task automatic test_idle();
    for (int t = 0; t < 5; t++) begin
      tick();
      checkCount++; if (gnt !== 3'b000) $display("[TB] FAIL idle_gnt t%0d: got %b want 000", t, gnt); else passCount++;
      checkCount++; if (mem_write_enable !== 1'b0) $display("[TB] FAIL idle_we t%0d: got %b want 0", t, mem_write_enable); else passCount++;
    end
    checkCount++; if (mem_address !== 16'h0200) $display("[TB] FAIL idle_addr_hold: got %h want 0200", mem_address); else passCount++;
  endtask

  initial begin
    passCount  = 0;
    checkCount = 0;
    test_reset();
    test_single_read();
    test_round_robin();
    test_burst_lock();
    test_back_to_back();
    test_reset_mid();
    test_idle();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
